// File: rtl/automaton_pkg.sv
// automaton_pkg: shared definitions for the 1-D cellular automaton controller.
//   ROWS_DEF / COLS_DEF : default frame geometry (rows held by the frame memory, cells per row)
//   state_t             : controller FSM state encoding
//   SEED / seed_col()   : seed row, a single live cell in the middle column
package automaton_pkg;

  localparam int ROWS_DEF = 60;
  localparam int COLS_DEF = 80;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  function automatic int seed_col(input int cols);
    return cols / 2;
  endfunction

  localparam logic [COLS_DEF-1:0] SEED = COLS_DEF'(1) << seed_col(COLS_DEF);

endpackage

// File: rtl/automaton_if.sv
// automaton_if: control/display-side signal bundle of automaton_ctrl.
//   master (sequencer side) drives : vga_row, frame_tick, run, step, seed_load, rule
//   slave  (automaton_ctrl) drives : rowW, dataW, busy, gen_count, overrun
interface automaton_if
  import automaton_pkg::*;
#(
  parameter int COLS = COLS_DEF
) ();

  logic [6:0]      vga_row;
  logic            frame_tick;
  logic            run;
  logic            step;
  logic            seed_load;
  logic [7:0]      rule;
  logic [6:0]      rowW;
  logic [COLS-1:0] dataW;
  logic            busy;
  logic [15:0]     gen_count;
  logic            overrun;

  modport master (
    output vga_row, frame_tick, run, step, seed_load, rule,
    input  rowW, dataW, busy, gen_count, overrun
  );

  modport slave (
    input  vga_row, frame_tick, run, step, seed_load, rule,
    output rowW, dataW, busy, gen_count, overrun
  );

endinterface

// File: rtl/ca_rule_eval.sv
// ca_rule_eval: combinational next-generation evaluator for an elementary
// (Wolfram-numbered) cellular automaton.
//   gen_i  : current generation, bit i is column i
//   rule_i : 8-bit rule number
//   next_o : next generation
// Build option AUTOMATON_WRAP_EN: toroidal edges (column -1 is COLS-1, column
// COLS is 0). Without it, cells beyond the edges read as dead.
module ca_rule_eval
  import automaton_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic [COLS-1:0] gen_i,
  input  logic [7:0]      rule_i,
  output logic [COLS-1:0] next_o
);

  // pad[j+1] is column j; pad[0] is column -1 and pad[COLS+1] is column COLS.
  logic [COLS+1:0] pad;

  always_comb begin
`ifdef AUTOMATON_WRAP_EN
    pad = {gen_i[0], gen_i, gen_i[COLS-1]};
`else
    pad = {1'b0, gen_i, 1'b0};
`endif
  end

  always_comb begin
    next_o = '0;
    for (int i = 0; i < COLS; i++) begin
      // left neighbour is the MSB of the rule index
      next_o[i] = rule_i[{pad[i], pad[i+1], pad[i+2]}];
    end
  end

endmodule

// File: rtl/automaton_ctrl.sv
// automaton_ctrl: generation sequencer for a 1-D cellular automaton drawn one
// row per generation into a scrolling frame memory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : automaton_if.slave
//     inputs  vga_row (row being displayed), frame_tick, run, step, seed_load, rule
//     outputs rowW/dataW (frame memory write row/data), busy, gen_count, overrun
// Parameters: ROWS, COLS, FRAME_DIV (frame ticks per generation when running, 1..255).
// Build option AUTOMATON_WRAP_EN selects toroidal edges inside ca_rule_eval.
//
// state    | meaning
// IDLE     | waiting for a trigger; rowW/dataW hold the last committed row
// COMPUTE  | evaluating the next generation with the current rule
// WRITE    | presenting wr_row/gen until the display is off that row
module automaton_ctrl
  import automaton_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  automaton_if.slave  bus
);

  localparam logic [COLS-1:0] SEED_ROW = COLS'(1) << seed_col(COLS);

  state_t          state_q;
  logic [COLS-1:0] gen_q;
  logic [6:0]      wr_row_q;
  logic [6:0]      row_w_q;
  logic [COLS-1:0] data_w_q;
  logic [15:0]     gen_count_q;
  logic            overrun_q;
  logic [7:0]      frame_cnt_q;
  // the row in flight is the seed, which is not a generation
  logic            seed_wr_q;

  logic [COLS-1:0] next_gen;
  logic            frame_last;
  logic            trigger;
  logic [7:0]      frame_cnt_d;
  logic [6:0]      wr_row_d;

  ca_rule_eval #(.COLS(COLS)) u_rule_eval (
    .gen_i  (gen_q),
    .rule_i (bus.rule),
    .next_o (next_gen)
  );

  always_comb begin
    frame_last = (frame_cnt_q == 8'(FRAME_DIV - 1));
    trigger    = (bus.run && bus.frame_tick && frame_last) || (!bus.run && bus.step);

    frame_cnt_d = frame_cnt_q;
    if (bus.frame_tick) begin
      frame_cnt_d = frame_last ? 8'd0 : frame_cnt_q + 8'd1;
    end

    wr_row_d = (wr_row_q == 7'(ROWS - 1)) ? 7'd0 : wr_row_q + 7'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gen_q       <= SEED_ROW;
      wr_row_q    <= '0;
      row_w_q     <= '0;
      data_w_q    <= '0;
      gen_count_q <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      seed_wr_q   <= 1'b0;
    end else if (bus.seed_load) begin
      // restart wins over any trigger and aborts an in-flight generation
      state_q     <= ST_WRITE;
      gen_q       <= SEED_ROW;
      wr_row_q    <= '0;
      row_w_q     <= '0;
      data_w_q    <= SEED_ROW;
      gen_count_q <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      seed_wr_q   <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      if (trigger && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (trigger) state_q <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          gen_q    <= next_gen;
          row_w_q  <= wr_row_q;
          data_w_q <= next_gen;
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          // the memory refuses the row under the display beam, so wait it out
          if (bus.vga_row != row_w_q) begin
            wr_row_q  <= wr_row_d;
            seed_wr_q <= 1'b0;
            if (!seed_wr_q) gen_count_q <= gen_count_q + 16'd1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rowW      = row_w_q;
  assign bus.dataW     = data_w_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.gen_count = gen_count_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_automaton_ctrl.sv
module tb_automaton_ctrl;
  import automaton_pkg::*;

  localparam int ROWS      = 60;
  localparam int COLS      = 80;
  localparam int FRAME_DIV = 2;
`ifdef AUTOMATON_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  automaton_if #(.COLS(COLS)) bus ();

  automaton_ctrl #(.ROWS(ROWS), .COLS(COLS), .FRAME_DIV(FRAME_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // frame memory as seen by the display: writes land unless the row is being read
  logic [COLS-1:0] fmem [ROWS];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) fmem[i] <= '0;
    end else if (bus.rowW != bus.vga_row && int'(bus.rowW) < ROWS) begin
      fmem[bus.rowW] <= bus.dataW;
    end
  end

  // reference model: picture of the automaton history
  logic [COLS-1:0] ref_gen;
  logic [COLS-1:0] ref_mem [ROWS];
  int              ref_wr;
  int              ref_cnt;
  logic [COLS-1:0] seed_row;

  function automatic logic [COLS-1:0] ref_next(input logic [COLS-1:0] g, input logic [7:0] r);
    logic [COLS-1:0] n;
    int l, c, rt;
    n = '0;
    for (int i = 0; i < COLS; i++) begin
      c = int'(g[i]);
      if (i == 0) l = WRAP ? int'(g[COLS-1]) : 0;
      else        l = int'(g[i-1]);
      if (i == COLS-1) rt = WRAP ? int'(g[0]) : 0;
      else             rt = int'(g[i+1]);
      n[i] = r[l*4 + c*2 + rt];
    end
    return n;
  endfunction

  task automatic ref_reset();
    ref_gen = seed_row; ref_wr = 0; ref_cnt = 0;
  endtask

  task automatic ref_seed();
    ref_gen = seed_row; ref_mem[0] = seed_row; ref_wr = 1; ref_cnt = 0;
  endtask

  task automatic ref_step(input logic [7:0] r);
    ref_gen = ref_next(ref_gen, r);
    ref_mem[ref_wr] = ref_gen;
    ref_wr = (ref_wr + 1) % ROWS;
    ref_cnt++;
  endtask

  task automatic wait_idle(input int max, input bit rnd, input int hot);
    int n = 0;
    while (bus.busy && n < max) begin
      if (rnd) bus.vga_row = ($urandom_range(0, 2) == 0) ? 7'(hot) : 7'($urandom_range(0, ROWS-1));
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", bus.busy, max);
    end
  endtask

  task automatic pulse_seed();
    @(negedge clk) bus.seed_load = 1'b1;
    @(negedge clk) bus.seed_load = 1'b0;
  endtask

  task automatic pulse_step(input logic [7:0] r);
    @(negedge clk) begin bus.rule = r; bus.step = 1'b1; end
    @(negedge clk) bus.step = 1'b0;
  endtask

  task automatic test_reset();
    logic [COLS-1:0] e;
    rst = 1'b1;
    bus.vga_row = 7'd30; bus.frame_tick = 0; bus.run = 0; bus.step = 0; bus.seed_load = 0; bus.rule = 8'h1E;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.rowW !== 7'd0) begin errors++; $display("FAIL reset_rowW: got %0d expected 0", bus.rowW); end
    checks++; if (bus.dataW !== '0) begin errors++; $display("FAIL reset_dataW: got %h expected 0", bus.dataW); end
    checks++; if (bus.gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count: got %0d expected 0", bus.gen_count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", bus.overrun); end
    rst = 1'b0;
    ref_reset();
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_no_trigger: busy=%0b expected 0", bus.busy); end
    // without a seed_load the first generation grows from the seed into row 0
    pulse_step(8'h1E);
    wait_idle(20, 1'b0, 0);
    ref_step(8'h1E);
    e = ref_gen;
    checks++; if (bus.rowW !== 7'd0 || bus.dataW !== e) begin errors++; $display("FAIL reset_first_gen: row %0d data %h expected row 0 data %h", bus.rowW, bus.dataW, e); end
    checks++; if (bus.gen_count !== 16'd1) begin errors++; $display("FAIL reset_first_count: got %0d expected 1", bus.gen_count); end
  endtask

  task automatic test_seed_step();
    logic [COLS-1:0] e1;
    e1 = '0; e1[39] = 1'b1; e1[40] = 1'b1; e1[41] = 1'b1;
    bus.vga_row = 7'd30;
    pulse_seed();
    ref_seed();
    checks++; if (bus.busy !== 1'b1 || bus.rowW !== 7'd0 || bus.dataW !== seed_row) begin errors++; $display("FAIL seed_write: busy %0b row %0d data %h expected busy 1 row 0 data %h", bus.busy, bus.rowW, bus.dataW, seed_row); end
    checks++; if (bus.gen_count !== 16'd0) begin errors++; $display("FAIL seed_count: got %0d expected 0", bus.gen_count); end
    wait_idle(10, 1'b0, 0);
    @(negedge clk) begin bus.rule = 8'h1E; bus.step = 1'b1; end
    @(negedge clk) bus.step = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL latency_compute: busy %0b expected 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.rowW !== 7'd1 || bus.dataW !== e1) begin errors++; $display("FAIL latency_write: busy %0b row %0d data %h expected busy 1 row 1 data %h", bus.busy, bus.rowW, bus.dataW, e1); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.gen_count !== 16'd1) begin errors++; $display("FAIL latency_commit: busy %0b count %0d expected busy 0 count 1", bus.busy, bus.gen_count); end
    ref_step(8'h1E);
    checks++; if (fmem[0] !== seed_row) begin errors++; $display("FAIL seed_row0: got %h expected %h", fmem[0], seed_row); end
    checks++; if (fmem[1] !== e1 || ref_mem[1] !== e1) begin errors++; $display("FAIL step_row1: got %h model %h expected %h", fmem[1], ref_mem[1], e1); end
  endtask

  task automatic test_collision();
    logic [7:0] r;
    logic [COLS-1:0] e;
    bus.vga_row = 7'd30;
    pulse_seed(); ref_seed();
    wait_idle(10, 1'b0, 0);
    r = 8'($urandom);
    bus.vga_row = 7'd1;
    pulse_step(r);
    ref_step(r);
    e = ref_mem[1];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.rowW !== 7'd1 || bus.dataW !== e) begin
        errors++; $display("FAIL collision_hold[%0d]: busy %0b row %0d data %h expected busy 1 row 1 data %h", k, bus.busy, bus.rowW, bus.dataW, e);
      end
    end
    bus.vga_row = 7'd7;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.gen_count !== 16'd1) begin errors++; $display("FAIL collision_release: busy %0b count %0d expected busy 0 count 1", bus.busy, bus.gen_count); end
    checks++; if (fmem[1] !== e) begin errors++; $display("FAIL collision_row1: got %h expected %h", fmem[1], e); end
  endtask

  task automatic test_row_wrap();
    logic [7:0] r;
    int hot;
    bus.vga_row = 7'($urandom_range(0, ROWS-1));
    pulse_seed(); ref_seed();
    wait_idle(200, 1'b1, 0);
    for (int k = 1; k <= 61; k++) begin
      r = 8'($urandom);
      hot = ref_wr;
      pulse_step(r);
      wait_idle(200, 1'b1, hot);
      ref_step(r);
      checks++;
      if (int'(bus.rowW) != hot || bus.dataW !== ref_gen || int'(bus.gen_count) != ref_cnt) begin
        errors++; $display("FAIL wrap_gen[%0d]: row %0d data %h count %0d expected row %0d data %h count %0d", k, bus.rowW, bus.dataW, bus.gen_count, hot, ref_gen, ref_cnt);
      end
      if (k == 60) begin
        checks++; if (bus.rowW !== 7'd0) begin errors++; $display("FAIL wrap_row59_to_0: row %0d expected 0", bus.rowW); end
      end
    end
    checks++; if (bus.gen_count !== 16'd61) begin errors++; $display("FAIL wrap_count: got %0d expected 61", bus.gen_count); end
    bus.vga_row = 7'd100;
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (fmem[i] !== ref_mem[i]) begin errors++; $display("FAIL wrap_mem[%0d]: got %h expected %h", i, fmem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_column_edge();
    logic [COLS-1:0] e40, e41;
    e40 = '0; e40[0] = 1'b1;
    e41 = '0; if (WRAP) e41[COLS-1] = 1'b1;
    bus.vga_row = 7'd100;
    pulse_seed(); ref_seed();
    wait_idle(10, 1'b0, 0);
    for (int k = 1; k <= 41; k++) begin
      pulse_step(8'hAA);
      wait_idle(20, 1'b0, 0);
      ref_step(8'hAA);
      if (k == 40) begin
        checks++; if (bus.dataW !== e40) begin errors++; $display("FAIL edge_step40: got %h expected %h", bus.dataW, e40); end
      end
    end
    checks++; if (bus.dataW !== e41) begin errors++; $display("FAIL edge_step41: got %h expected %h", bus.dataW, e41); end
    checks++; if (bus.dataW !== ref_gen) begin errors++; $display("FAIL edge_model: got %h expected %h", bus.dataW, ref_gen); end
  endtask

  task automatic test_frame_div();
    logic [7:0] r;
    r = 8'h5A;
    bus.vga_row = 7'd100; bus.rule = r;
    pulse_seed(); ref_seed();
    wait_idle(10, 1'b0, 0);
    bus.run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      checks++;
      if (bus.busy !== ((k % FRAME_DIV) == 0)) begin errors++; $display("FAIL frame_tick[%0d]: busy %0b expected %0b", k, bus.busy, (k % FRAME_DIV) == 0); end
      if ((k % FRAME_DIV) == 0) ref_step(r);
      repeat (6) @(negedge clk);
    end
    checks++; if (bus.gen_count !== 16'd3 || int'(bus.gen_count) != ref_cnt) begin errors++; $display("FAIL frame_gens: got %0d expected 3", bus.gen_count); end
    checks++; if (bus.dataW !== ref_gen) begin errors++; $display("FAIL frame_data: got %h expected %h", bus.dataW, ref_gen); end
    // step is ignored while running
    @(negedge clk) bus.step = 1'b1;
    @(negedge clk) bus.step = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL run_step_ignored: busy %0b expected 0", bus.busy); end
    bus.run = 1'b0;
    @(negedge clk) bus.step = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.step = 1'b0;
    wait_idle(20, 1'b0, 0);
    ref_step(r);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b expected 1", bus.overrun); end
    checks++; if (int'(bus.gen_count) != ref_cnt) begin errors++; $display("FAIL overrun_count: got %0d expected %0d", bus.gen_count, ref_cnt); end
    pulse_seed(); ref_seed();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %0b expected 0", bus.overrun); end
    wait_idle(10, 1'b0, 0);
  endtask

  task automatic test_abort();
    bus.vga_row = 7'd100;
    pulse_seed(); ref_seed();
    wait_idle(10, 1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      pulse_step(8'h96); wait_idle(20, 1'b0, 0); ref_step(8'h96);
    end
    @(negedge clk) begin bus.rule = 8'h1E; bus.step = 1'b1; end
    @(negedge clk) begin bus.step = 1'b0; bus.seed_load = 1'b1; end
    @(negedge clk) bus.seed_load = 1'b0;
    ref_seed();
    checks++; if (bus.busy !== 1'b1 || bus.rowW !== 7'd0 || bus.dataW !== seed_row || bus.gen_count !== 16'd0) begin
      errors++; $display("FAIL abort_seed: busy %0b row %0d data %h count %0d expected 1/0/%h/0", bus.busy, bus.rowW, bus.dataW, bus.gen_count, seed_row);
    end
    wait_idle(10, 1'b0, 0);
    checks++; if (fmem[0] !== ref_mem[0] || bus.gen_count !== 16'd0) begin errors++; $display("FAIL abort_row0: got %h count %0d expected %h count 0", fmem[0], bus.gen_count, ref_mem[0]); end
    bus.vga_row = 7'(ref_wr);
    @(negedge clk) begin bus.rule = 8'h1E; bus.step = 1'b1; end
    @(negedge clk);
    @(negedge clk) bus.step = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.rowW !== 7'd1 || bus.overrun !== 1'b1) begin errors++; $display("FAIL abort_pre_rst: busy %0b row %0d overrun %0b expected 1/1/1", bus.busy, bus.rowW, bus.overrun); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.rowW !== 7'd0 || bus.dataW !== '0 || bus.gen_count !== 16'd0 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL abort_rst_async: busy %0b row %0d data %h count %0d overrun %0b expected all 0", bus.busy, bus.rowW, bus.dataW, bus.gen_count, bus.overrun);
    end
    @(negedge clk) rst = 1'b0;
    ref_reset();
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed_row = '0;
    seed_row[COLS/2] = 1'b1;
    test_reset();
    test_seed_step();
    test_collision();
    test_row_wrap();
    test_column_edge();
    test_frame_div();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
